// File: rtl/cart_rom_responder.sv
// Cart-bus ROM responder: debounces the board address, serves 16-bit words from a
// two-slot buffer and fills misses/prefetches over a variable-latency req/ack port.
module cart_rom_responder #(
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned SETTLE_CYC = 2,
    parameter bit          PREFETCH   = 1'b1
) (
    input  logic              MCLK,
    input  logic              SRES,
    input  logic [ADDR_W-1:0] cart_address,
    input  logic              cart_cs,
    input  logic              cart_oe,
    output logic [15:0]       cart_data,
    input  logic [ADDR_W-1:0] rom_mask,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic [15:0]       miss_count
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSettle = 3'd1;
    localparam logic [2:0] StFetch  = 3'd2;
    localparam logic [2:0] StPref   = 3'd3;
    localparam logic [2:0] StServed = 3'd4;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] la_q, la_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       cart_data_q, cart_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       miss_q, miss_d;
    logic              pend_q, pend_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] tag_q [2];
    logic [ADDR_W-1:0] tag_d [2];
    logic [15:0]       data_q [2];
    logic [15:0]       data_d [2];
    logic [1:0]        v_q, v_d;

    logic              sel;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] la_next;
    logic              hit0, hit1, hit_slot, next_cached;
    logic [2:0]        post_state;

    assign sel         = cart_cs & cart_oe;
    assign ea          = cart_address & rom_mask;
    assign la_next     = (la_q + ADDR_W'(1)) & rom_mask;
    assign hit0        = v_q[0] && (tag_q[0] == la_q);
    assign hit1        = v_q[1] && (tag_q[1] == la_q);
    assign hit_slot    = hit0 ? 1'b0 : 1'b1;
    assign next_cached = (v_q[0] && (tag_q[0] == la_next)) || (v_q[1] && (tag_q[1] == la_next));
    assign post_state  = !sel ? StIdle : ((ea == la_q) ? StServed : StSettle);

    assign busy       = (state_q == StFetch) || (state_q == StPref);
    assign mem_req    = busy;
    assign mem_addr   = mem_addr_q;
    assign cart_data  = cart_data_q;
    assign miss_count = miss_q;

    always_comb begin
        state_d     = state_q;
        la_d        = la_q;
        cnt_d       = cnt_q;
        cart_data_d = cart_data_q;
        mem_addr_d  = mem_addr_q;
        miss_d      = miss_q;
        pend_d      = pend_q;
        kill_d      = kill_q;
        tag_d       = tag_q;
        data_d      = data_q;
        v_d         = v_q;

        case (state_q)
            StIdle: begin
                if (sel) begin
                    la_d    = ea;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!sel) begin
                    state_d = StIdle;
                end else if (ea != la_q) begin
                    la_d  = ea;
                    cnt_d = '0;
                end else if (cnt_q == SettleLast) begin
                    if (hit0 || hit1) begin
                        cart_data_d = data_q[hit_slot];
                        if (PREFETCH && !next_cached) begin
                            pend_d     = ~hit_slot;
                            mem_addr_d = la_next;
                            state_d    = StPref;
                        end else begin
                            state_d = StServed;
                        end
                    end else begin
                        mem_addr_d = la_q;
                        if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StFetch: begin
                if (mem_ack) begin
                    cart_data_d = mem_rdata;
                    if (!kill_q) begin
                        tag_d[0]  = la_q;
                        data_d[0] = mem_rdata;
                        v_d[0]    = 1'b1;
                    end
                    if (PREFETCH) begin
                        pend_d     = 1'b1;
                        mem_addr_d = la_next;
                        state_d    = StPref;
                    end else begin
                        state_d = post_state;
                        la_d    = ea;
                        cnt_d   = '0;
                    end
                end
            end
            StPref: begin
                // Address changes seen while prefetching are only acted on after the ack.
                if (mem_ack) begin
                    if (!kill_q) begin
                        tag_d[pend_q]  = mem_addr_q;
                        data_d[pend_q] = mem_rdata;
                        v_d[pend_q]    = 1'b1;
                    end
                    state_d = post_state;
                    la_d    = ea;
                    cnt_d   = '0;
                end
            end
            StServed: begin
                if (!sel) begin
                    state_d = StIdle;
                end else if (ea != la_q) begin
                    la_d    = ea;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A flush seen mid-transaction suppresses that transaction's slot fill.
        if (busy) begin
            kill_d = mem_ack ? 1'b0 : (kill_q | flush);
        end else begin
            kill_d = 1'b0;
        end
        if (flush) v_d = 2'b00;
    end

    always_ff @(posedge MCLK) begin
        if (!SRES) begin
            state_q     <= StIdle;
            la_q        <= '0;
            cnt_q       <= '0;
            cart_data_q <= '0;
            mem_addr_q  <= '0;
            miss_q      <= '0;
            pend_q      <= 1'b0;
            kill_q      <= 1'b0;
            tag_q       <= '{default: '0};
            data_q      <= '{default: '0};
            v_q         <= 2'b00;
        end else begin
            state_q     <= state_d;
            la_q        <= la_d;
            cnt_q       <= cnt_d;
            cart_data_q <= cart_data_d;
            mem_addr_q  <= mem_addr_d;
            miss_q      <= miss_d;
            pend_q      <= pend_d;
            kill_q      <= kill_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            v_q         <= v_d;
        end
    end

endmodule

// File: tb/tb_cart_rom_responder.sv
// Bench for cart_rom_responder: table of board reads plus hand sequences for jitter,
// flush and reset; a responder model checks each memory request against a queue.
module tb_cart_rom_responder;

    localparam int AW = 21;

    logic          MCLK;
    logic          SRES;
    logic [AW-1:0] cart_address;
    logic          cart_cs;
    logic          cart_oe;
    logic [15:0]   cart_data;
    logic [AW-1:0] rom_mask;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [15:0]   mem_rdata;
    logic          busy;
    logic [15:0]   miss_count;

    cart_rom_responder #(
        .ADDR_W    (AW),
        .SETTLE_CYC(2),
        .PREFETCH  (1'b1)
    ) dut (
        .MCLK        (MCLK),
        .SRES        (SRES),
        .cart_address(cart_address),
        .cart_cs     (cart_cs),
        .cart_oe     (cart_oe),
        .cart_data   (cart_data),
        .rom_mask    (rom_mask),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .miss_count  (miss_count)
    );

    int tests = 0;
    int fails = 0;
    int mode  = 0;  // 0 silent, 1 auto-ack, 2 free-running ack toggle
    int lat   = 5;
    int wait_cnt;
    logic [AW-1:0] exp_req_q[$];
    logic [AW-1:0] exp_addr;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] mask;
        bit            miss;
        logic [15:0]   exp_data;
        bit            pref;
        logic [AW-1:0] pref_addr;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        case (a)
            21'h000100: return 16'hA55A;
            21'h000101: return 16'h1234;
            21'h000200: return 16'hBEEF;
            default:    return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge MCLK);
            if (mem_ack) begin
                seen = 1;
                break;
            end
        end
        #1;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: got no mem_ack expected ack within 40 cycles", name);
        end
    endtask

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    // Memory model: acks each request after lat cycles and checks it against the queue.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        wait_cnt  = 0;
        forever begin
            @(negedge MCLK);
            if (mode == 2) begin
                mem_ack   = ~mem_ack;
                mem_rdata = 16'hFFFF;
            end else if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mode == 1 && mem_req) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    wait_cnt  = 0;
                    if (exp_req_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_req: got %0h expected no request", mem_addr);
                    end else begin
                        exp_addr = exp_req_q.pop_front();
                        check("req_addr", 32'(mem_addr), 32'(exp_addr));
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] prev_data;
        logic [15:0] prev_miss;

        vecs[0] = '{21'h000100, 21'h1FFFFF, 1'b1, 16'hA55A, 1'b1, 21'h000101};
        vecs[1] = '{21'h000101, 21'h1FFFFF, 1'b0, 16'h1234, 1'b1, 21'h000102};
        vecs[2] = '{21'h000102, 21'h1FFFFF, 1'b0, mem_word(21'h000102), 1'b1, 21'h000103};
        vecs[3] = '{21'h000100, 21'h1FFFFF, 1'b1, 16'hA55A, 1'b1, 21'h000101};
        vecs[4] = '{21'h1FFFFF, 21'h0FFFFF, 1'b1, mem_word(21'h0FFFFF), 1'b1, 21'h000000};
        vecs[5] = '{21'h100000, 21'h0FFFFF, 1'b0, mem_word(21'h000000), 1'b1, 21'h000001};

        // Reset hold with the bus selected and ack toggling.
        SRES         = 1'b0;
        cart_cs      = 1'b1;
        cart_oe      = 1'b1;
        cart_address = 21'h000100;
        rom_mask     = 21'h1FFFFF;
        flush        = 1'b0;
        mode         = 2;
        for (int i = 0; i < 4; i++) begin
            @(posedge MCLK);
            #1;
            check("rst_cart_data", 32'(cart_data), 32'h0);
            check("rst_mem_req", 32'(mem_req), 32'h0);
            check("rst_miss_count", 32'(miss_count), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
        end
        @(negedge MCLK);
        cart_cs = 1'b0;
        mode    = 0;
        repeat (2) @(negedge MCLK);
        SRES = 1'b1;
        mode = 1;

        for (int i = 0; i < 6; i++) begin
            @(negedge MCLK);
            cart_cs = 1'b0;
            @(negedge MCLK);
            cart_address = vecs[i].addr;
            rom_mask     = vecs[i].mask;
            cart_cs      = 1'b1;
            cart_oe      = 1'b1;
            prev_data    = cart_data;
            prev_miss    = miss_count;
            if (vecs[i].miss) exp_req_q.push_back(vecs[i].addr & vecs[i].mask);
            if (vecs[i].pref) exp_req_q.push_back(vecs[i].pref_addr);
            if (vecs[i].miss) begin
                wait_ack($sformatf("vec%0d_demand_ack", i));
                check($sformatf("vec%0d_data", i), 32'(cart_data), 32'(vecs[i].exp_data));
                check($sformatf("vec%0d_miss", i), 32'(miss_count), 32'(prev_miss + 16'd1));
            end else begin
                repeat (2) @(posedge MCLK);
                #1;
                check($sformatf("vec%0d_not_early", i), 32'(cart_data), 32'(prev_data));
                @(posedge MCLK);
                #1;
                check($sformatf("vec%0d_hit_data", i), 32'(cart_data), 32'(vecs[i].exp_data));
                check($sformatf("vec%0d_hit_miss", i), 32'(miss_count), 32'(prev_miss));
                check($sformatf("vec%0d_pref_req", i), 32'(mem_req), 32'(vecs[i].pref));
            end
            if (vecs[i].pref) begin
                wait_ack($sformatf("vec%0d_pref_ack", i));
                check($sformatf("vec%0d_pref_keep", i), 32'(cart_data), 32'(vecs[i].exp_data));
            end
            check($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'h0);
            check($sformatf("vec%0d_reqs_left", i), 32'(exp_req_q.size()), 32'h0);
        end

        // Address jitter: only a stable address may be looked up.
        @(negedge MCLK);
        cart_cs   = 1'b0;
        rom_mask  = 21'h1FFFFF;
        prev_miss = miss_count;
        @(negedge MCLK);
        cart_address = 21'h000010;
        cart_cs      = 1'b1;
        exp_req_q.push_back(21'h000010);
        exp_req_q.push_back(21'h000011);
        @(negedge MCLK);
        cart_address = 21'h000011;
        @(negedge MCLK);
        cart_address = 21'h000010;
        @(posedge MCLK);
        #1;
        check("jit_no_req_a", 32'(mem_req), 32'h0);
        @(posedge MCLK);
        #1;
        check("jit_no_req_b", 32'(mem_req), 32'h0);
        @(posedge MCLK);
        #1;
        check("jit_req", 32'(mem_req), 32'h1);
        check("jit_req_addr", 32'(mem_addr), 32'h10);
        wait_ack("jit_demand_ack");
        check("jit_data", 32'(cart_data), 32'(mem_word(21'h000010)));
        check("jit_miss", 32'(miss_count), 32'(prev_miss + 16'd1));
        wait_ack("jit_pref_ack");
        check("jit_reqs_left", 32'(exp_req_q.size()), 32'h0);

        // Flush during a demand fetch: data still served, slot left invalid.
        @(negedge MCLK);
        cart_cs   = 1'b0;
        prev_miss = miss_count;
        @(negedge MCLK);
        cart_address = 21'h000200;
        cart_cs      = 1'b1;
        exp_req_q.push_back(21'h000200);
        exp_req_q.push_back(21'h000201);
        repeat (3) @(posedge MCLK);
        #1;
        check("fl_fetch_req", 32'(mem_req), 32'h1);
        @(negedge MCLK);
        flush = 1'b1;
        @(negedge MCLK);
        flush = 1'b0;
        wait_ack("fl_demand_ack");
        check("fl_data", 32'(cart_data), 32'hBEEF);
        wait_ack("fl_pref_ack");
        check("fl_busy", 32'(busy), 32'h0);
        @(negedge MCLK);
        cart_cs = 1'b0;
        @(negedge MCLK);
        cart_cs = 1'b1;
        exp_req_q.push_back(21'h000200);
        exp_req_q.push_back(21'h000201);
        wait_ack("fl_refetch_ack");
        check("fl_refetch_data", 32'(cart_data), 32'hBEEF);
        check("fl_miss", 32'(miss_count), 32'(prev_miss + 16'd2));
        wait_ack("fl_refetch_pref_ack");
        check("fl_reqs_left", 32'(exp_req_q.size()), 32'h0);

        @(negedge MCLK);
        cart_cs = 1'b0;
        repeat (3) @(negedge MCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
